// File: rtl/cpu_pkg.sv
// Shared instruction-set constants for the control-unit decoder and the imem loader/encoder.
package cpu_pkg;

    localparam int unsigned COND_W  = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned SRC2_W  = 12;
    localparam int unsigned IMM24_W = 24;
    localparam int unsigned INSTR_W = 32;

    localparam logic [OP_W-1:0] OP_CODE_DP  = 2'b00;
    localparam logic [OP_W-1:0] OP_CODE_MEM = 2'b01;
    localparam logic [OP_W-1:0] OP_CODE_B   = 2'b10;

    localparam logic [3:0] FUNCT_4_1_AND = 4'b0000;
    localparam logic [3:0] FUNCT_4_1_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_4_1_ADD = 4'b0100;
    localparam logic [3:0] FUNCT_4_1_ORR = 4'b1100;

    localparam logic FUNCT_0_LDR = 1'b1;
    localparam logic FUNCT_0_STR = 1'b0;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    typedef struct packed {
        logic [COND_W-1:0]  cond;
        logic [OP_W-1:0]    op;
        logic [FUNCT_W-1:0] funct;
        logic [REG_W-1:0]   rn;
        logic [REG_W-1:0]   rd;
        logic [SRC2_W-1:0]  src2;
        logic [IMM24_W-1:0] imm24;
    } instr_fields_t;

    // Data-processing ops the datapath ALU actually implements.
    function automatic logic dp_funct_legal(input logic [3:0] funct_4_1);
        return (funct_4_1 == FUNCT_4_1_AND) || (funct_4_1 == FUNCT_4_1_SUB) ||
               (funct_4_1 == FUNCT_4_1_ADD) || (funct_4_1 == FUNCT_4_1_ORR);
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer: decoded fields -> 32-bit ARM-subset word plus an illegal flag.
module instr_encoder
    import cpu_pkg::*;
(
    input  instr_fields_t        fields,
    output logic [INSTR_W-1:0]   word_c,
    output logic                 illegal_c
);

    always_comb begin
        word_c    = '0;
        illegal_c = 1'b0;
        case (fields.op)
            OP_CODE_DP, OP_CODE_MEM: begin
                word_c = {fields.cond, fields.op, fields.funct,
                          fields.rn, fields.rd, fields.src2};
            end
            OP_CODE_B: begin
                word_c = {fields.cond, fields.op, fields.funct[5:4], fields.imm24};
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
        if (fields.cond == COND_NV) begin
            illegal_c = 1'b1;
        end
        if ((fields.op == OP_CODE_DP) && !dp_funct_legal(fields.funct[4:1])) begin
            illegal_c = 1'b1;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Streams decoded instructions into instruction memory and holds the CPU until loading completes.
module imem_program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_cond,
    input  logic [1:0]          in_op,
    input  logic [5:0]          in_funct,
    input  logic [3:0]          in_rn,
    input  logic [3:0]          in_rd,
    input  logic [11:0]         in_src2,
    input  logic [23:0]         in_imm24,
    input  logic                in_last,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_run,
    output logic                busy,
    output logic                err_illegal,
    output logic                err_overflow,
    output logic [ADDR_W:0]     word_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    loader_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0]    wc_q, wc_d;
    logic                we_q, we_d;
    logic                ill_q, ill_d;
    logic                ovf_q, ovf_d;
    logic                ready_q, ready_d;
    logic                run_q, run_d;
    logic                busy_q, busy_d;

    instr_fields_t       fields;
    logic [INSTR_W-1:0]  enc_word;
    logic                enc_illegal;
    logic                accept;

    assign fields = '{cond: in_cond, op: in_op, funct: in_funct, rn: in_rn,
                      rd: in_rd, src2: in_src2, imm24: in_imm24};

    instr_encoder u_encoder (
        .fields    (fields),
        .word_c    (enc_word),
        .illegal_c (enc_illegal)
    );

    assign accept = in_valid && ready_q && (state_q == ST_LOAD);

    // Next-state, pointer and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        wc_d    = wc_q + CNT_W'(we_q);
        ill_d   = ill_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = ADDR_W'(BASE_ADDR);
                    wc_d    = '0;
                    ill_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (enc_illegal) begin
                        ill_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + ADDR_W'(1);
                    end
                    if (in_last) begin
                        state_d = ST_FLUSH;
                    end
                end else if (wc_d == CNT_W'(DEPTH)) begin
                    state_d = ST_FLUSH;
                    ovf_d   = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The pending write is counted so the last free slot is never handed out twice.
        ready_d = (state_d == ST_LOAD) && ((wc_d + CNT_W'(we_d)) < CNT_W'(DEPTH));
        run_d   = (state_d == ST_DONE);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wc_q    <= '0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wc_q    <= wc_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready     = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_run      = run_q;
    assign busy         = busy_q;
    assign err_illegal  = ill_q;
    assign err_overflow = ovf_q;
    assign word_count   = wc_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: directed spec cases plus randomized sessions against a field-level model.
module tb_imem_program_loader;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, in_last;
    logic [3:0]  in_cond, in_rn, in_rd;
    logic [1:0]  in_op;
    logic [5:0]  in_funct;
    logic [11:0] in_src2;
    logic [23:0] in_imm24;

    logic        rdy_b, we_b, run_b, busy_b, ill_b, ovf_b;
    logic [5:0]  addr_b;
    logic [31:0] wdata_b;
    logic [6:0]  wc_b;

    logic        rdy_s, we_s, run_s, busy_s, ill_s, ovf_s;
    logic [1:0]  addr_s;
    logic [31:0] wdata_s;
    logic [2:0]  wc_s;

    imem_program_loader #(.ADDR_W(6), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
        .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd),
        .in_src2(in_src2), .in_imm24(in_imm24), .in_last(in_last),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .cpu_run(run_b),
        .busy(busy_b), .err_illegal(ill_b), .err_overflow(ovf_b), .word_count(wc_b)
    );

    imem_program_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_s),
        .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd),
        .in_src2(in_src2), .in_imm24(in_imm24), .in_last(in_last),
        .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s), .cpu_run(run_s),
        .busy(busy_s), .err_illegal(ill_s), .err_overflow(ovf_s), .word_count(wc_s)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          mptr = 0;
    int          nwr_b = 0;
    int          exp_addr_prev = 0;
    logic [31:0] exp_word_prev = '0;
    bit          acc_prev = 1'b0;
    bit          acc_sel = 1'b0;
    bit          sel_small = 1'b0;
    logic [63:0] log_b[$];
    int          logc_b[$];
    logic [63:0] log_s[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: legality and encoding computed from field values with plain arithmetic.
    function automatic bit m_legal(input beat_t b);
        int unsigned f41;
        f41 = (32'(b.funct) / 2) % 16;
        if (b.op == 2'd3) return 1'b0;
        if (b.cond == 4'd15) return 1'b0;
        if (b.op == 2'd0) return (f41 == 0) || (f41 == 2) || (f41 == 4) || (f41 == 12);
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_word(input beat_t b);
        int unsigned w;
        w = 32'(b.cond) * 32'h1000_0000 + 32'(b.op) * 32'h0400_0000;
        if (b.op == 2'd2)
            w = w + (32'(b.funct) / 16) * 32'h0100_0000 + 32'(b.imm24);
        else
            w = w + 32'(b.funct) * 32'h0010_0000 + 32'(b.rn) * 32'h1_0000
                  + 32'(b.rd) * 32'h1000 + 32'(b.src2);
        return w;
    endfunction

    function automatic beat_t mk(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                                 input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                                 input logic [23:0] i, input logic l);
        beat_t b;
        b.cond = c; b.op = o; b.funct = f; b.rn = n; b.rd = d; b.src2 = s; b.imm24 = i; b.last = l;
        return b;
    endfunction

    function automatic beat_t gen_beat(input bit last);
        beat_t b;
        int unsigned r;
        int unsigned codes[4] = '{0, 2, 4, 12};
        r = $urandom % 8;
        b.op    = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r == 6) ? 2'd2 : 2'd3;
        b.cond  = ($urandom % 10 == 0) ? 4'd15 : 4'($urandom % 15);
        b.funct = 6'($urandom);
        if (b.op == 2'd0 && ($urandom % 5 != 0))
            b.funct = {1'($urandom), 4'(codes[$urandom % 4]), 1'($urandom)};
        b.rn = 4'($urandom); b.rd = 4'($urandom);
        b.src2 = 12'($urandom); b.imm24 = 24'($urandom);
        b.last = last;
        return b;
    endfunction

    function automatic beat_t cur();
        return mk(in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24, in_last);
    endfunction

    task automatic drive(input beat_t b);
        in_cond = b.cond; in_op = b.op; in_funct = b.funct; in_rn = b.rn; in_rd = b.rd;
        in_src2 = b.src2; in_imm24 = b.imm24; in_last = b.last;
    endtask

    // One clock: check the big DUT's write port at negedge, then advance the model at posedge.
    task automatic cycle();
        bit    ab, as_, lg;
        beat_t c;
        @(negedge clk);
        check("we_timing", 64'(we_b), 64'(acc_prev));
        if (acc_prev) begin
            check("wr_addr", 64'(addr_b), 64'(exp_addr_prev));
            check("wr_data", 64'(wdata_b), 64'(exp_word_prev));
        end
        if (we_b) begin
            nwr_b++;
            log_b.push_back({32'(addr_b), wdata_b});
            logc_b.push_back(cyc);
        end
        if (we_s) log_s.push_back({32'(addr_s), wdata_s});
        c   = cur();
        lg  = m_legal(c);
        ab  = in_valid && rdy_b && rst_n;
        as_ = in_valid && rdy_s && rst_n;
        @(posedge clk);
        acc_prev = ab && lg && rst_n;
        if (acc_prev) begin
            exp_addr_prev = mptr;
            exp_word_prev = m_word(c);
            mptr++;
        end
        acc_sel = sel_small ? as_ : ab;
        cyc++;
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, 64'(rdy_b), 64'd0);
        check({tag, "_imem_we"}, 64'(we_b), 64'd0);
        check({tag, "_imem_addr"}, 64'(addr_b), 64'd0);
        check({tag, "_imem_wdata"}, 64'(wdata_b), 64'd0);
        check({tag, "_cpu_run"}, 64'(run_b), 64'd0);
        check({tag, "_busy"}, 64'(busy_b), 64'd0);
        check({tag, "_err_illegal"}, 64'(ill_b), 64'd0);
        check({tag, "_err_overflow"}, 64'(ovf_b), 64'd0);
        check({tag, "_word_count"}, 64'(wc_b), 64'd0);
    endtask

    task automatic pulse_start();
        mptr = 0; nwr_b = 0;
        log_b.delete(); logc_b.delete(); log_s.delete();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic send(input beat_t b);
        int k;
        drive(b);
        in_valid = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!acc_sel && k < 20);
        check("handshake", 64'(acc_sel), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_session(input string tag, input beat_t prog[$], input int gap_max, input bit noise);
        int exp_n;
        bit exp_ill;
        int k;
        exp_n = 0; exp_ill = 1'b0;
        foreach (prog[i]) begin
            if (m_legal(prog[i])) exp_n++;
            else exp_ill = 1'b1;
        end
        pulse_start();
        check({tag, "_start_busy"}, 64'(busy_b), 64'd1);
        check({tag, "_start_run"}, 64'(run_b), 64'd0);
        check({tag, "_start_wc"}, 64'(wc_b), 64'd0);
        foreach (prog[i]) begin
            repeat ($urandom_range(0, gap_max)) begin
                if (noise && ($urandom % 4 == 0)) start = 1'b1;
                cycle();
                start = 1'b0;
            end
            send(prog[i]);
        end
        k = 0;
        while (!run_b && k < 10) begin
            cycle();
            k++;
        end
        check({tag, "_done_run"}, 64'(run_b), 64'd1);
        check({tag, "_writes"}, 64'(nwr_b), 64'(exp_n));
        check({tag, "_word_count"}, 64'(wc_b), 64'(exp_n));
        check({tag, "_err_illegal"}, 64'(ill_b), 64'(exp_ill));
        check({tag, "_err_overflow"}, 64'(ovf_b), 64'd0);
        check({tag, "_done_busy"}, 64'(busy_b), 64'd0);
        check({tag, "_done_ready"}, 64'(rdy_b), 64'd0);
    endtask

    initial begin
        beat_t prog[$];
        beat_t b;
        logic [31:0] exp_w[4];
        int k;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        drive(mk(4'd0, 2'd0, 6'd0, 4'd0, 4'd0, 12'd0, 24'd0, 1'b0));
        #1;
        check_zero("reset");
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // ADD R1,R2,#5 as a single-beat program.
        prog = '{mk(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b1)};
        run_session("add", prog, 0, 1'b0);
        check("add_word", log_b[0], {32'd0, 32'hE282_1005});

        // LDR / ORR / B back-to-back; also exercises start from DONE.
        prog = '{mk(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 12'h008, 24'd0, 1'b0),
                 mk(4'hE, 2'b00, 6'b011000, 4'd4, 4'd4, 12'h005, 24'd0, 1'b0),
                 mk(4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 12'd0, 24'hFFFFFE, 1'b1)};
        run_session("b2b", prog, 0, 1'b0);
        check("b2b_w0", log_b[0], {32'd0, 32'hE590_3008});
        check("b2b_w1", log_b[1], {32'd1, 32'hE184_4005});
        check("b2b_w2", log_b[2], {32'd2, 32'hEAFF_FFFE});
        check("b2b_gap01", 64'(logc_b[1] - logc_b[0]), 64'd1);
        check("b2b_gap12", 64'(logc_b[2] - logc_b[1]), 64'd1);

        // Illegal op=11 sandwiched between two legal beats.
        prog = '{mk(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b0),
                 mk(4'hE, 2'b11, 6'b000000, 4'd1, 4'd1, 12'h001, 24'd0, 1'b0),
                 mk(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 12'h008, 24'd0, 1'b1)};
        run_session("illegal", prog, 1, 1'b0);
        check("illegal_w1", log_b[1], {32'd1, 32'hE590_3008});

        // Illegal final beat still ends the session.
        prog = '{mk(4'hE, 2'b01, 6'b011000, 4'd1, 4'd2, 12'h004, 24'd0, 1'b0),
                 mk(4'hF, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b1)};
        run_session("ill_last", prog, 0, 1'b0);

        // Overflow on the 4-word instance.
        sel_small = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            do b = gen_beat(1'b0); while (!m_legal(b));
            exp_w[i] = m_word(b);
            send(b);
        end
        check("ovf_ready_drop", 64'(rdy_s), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(gen_beat(1'b0));
            in_valid = 1'b1;
            repeat (3) begin
                cycle();
                check("ovf_no_accept", 64'(acc_sel), 64'd0);
            end
        end
        k = 0;
        while (!run_s && k < 10) begin
            cycle();
            k++;
        end
        in_valid = 1'b0;
        check("ovf_run", 64'(run_s), 64'd1);
        check("ovf_flag", 64'(ovf_s), 64'd1);
        check("ovf_wc", 64'(wc_s), 64'd4);
        check("ovf_busy", 64'(busy_s), 64'd0);
        check("ovf_illegal", 64'(ill_s), 64'd0);
        check("ovf_nwrites", 64'(log_s.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("ovf_word", log_s[i], {32'(i), exp_w[i]});
        sel_small = 1'b0;

        // Reset mid-load with a write in flight.
        rst_n = 1'b0; acc_prev = 1'b0;
        #1;
        rst_n = 1'b1;
        cycle();
        pulse_start();
        send(mk(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'd0, 1'b0));
        send(mk(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 12'h008, 24'd0, 1'b0));
        drive(mk(4'hE, 2'b00, 6'b011000, 4'd4, 4'd4, 12'h005, 24'd0, 1'b0));
        in_valid = 1'b1;
        cycle();
        check("rst_prior_writes", 64'(nwr_b), 64'd2);
        rst_n = 1'b0; acc_prev = 1'b0;
        #1;
        check_zero("midreset");
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        in_valid = 1'b0;
        check("rst_no_more_writes", 64'(nwr_b), 64'd2);
        check("rst_idle_ready", 64'(rdy_b), 64'd0);
        check("rst_idle_run", 64'(run_b), 64'd0);
        prog = '{gen_beat(1'b0), gen_beat(1'b0), gen_beat(1'b1)};
        run_session("reload", prog, 1, 1'b0);

        // Randomized sessions with gaps and ignored start pulses.
        for (int s = 0; s < 25; s++) begin
            int n;
            n = $urandom_range(1, 10);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(gen_beat(i == n - 1));
            run_session("rand", prog, 3, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
